eth_rx_hdr_parser: RTL and testbench
====================================

Name: eth_rx_hdr_parser

Overview:
- Sits directly downstream of the Ethernet MAC RX AXI-Stream output, in the same clock domain as the RX MAC.
- Splits each received frame into two outputs:
  - a 14-byte Ethernet header (destination MAC, source MAC, EtherType), presented on a valid/ready header port;
  - the remaining payload bytes, forwarded on an 8-bit AXI-Stream.
- Drops runt frames and frames errored in the header, and counts frames that are forwarded and frames that are dropped.

Parameters:
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- HDR_BYTES, 14, number of header bytes stripped from the start of each frame; fixed at 14.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- s_rx_axis_tdata  in  8  frame byte from the RX MAC.
- s_rx_axis_tvalid  in  1  input byte valid.
- s_rx_axis_tlast  in  1  last byte of the frame.
- s_rx_axis_tuser  in  1  frame error flag; meaningful on any beat.
- s_rx_axis_trdy  out  1  block accepts the input byte.
- m_hdr_valid  out  1  header fields are valid.
- m_hdr_rdy  in  1  consumer accepts the header.
- m_hdr_dest_mac  out  48  destination MAC; byte 0 of the frame is [47:40].
- m_hdr_src_mac  out  48  source MAC; byte 6 of the frame is [47:40].
- m_hdr_eth_type  out  16  EtherType; byte 12 is [15:8].
- m_pay_axis_tdata  out  8  payload byte.
- m_pay_axis_tvalid  out  1  payload byte valid.
- m_pay_axis_tlast  out  1  last payload byte.
- m_pay_axis_tuser  out  1  error flag, passed through from the input.
- m_pay_axis_trdy  in  1  downstream accepts the payload byte.
- stat_frames_ok  out  CNT_WIDTH  count of frames whose header was emitted; saturating.
- stat_frames_drop  out  CNT_WIDTH  count of frames dropped; saturating.

Behaviour:
- Clocking and reset: clk only; reset is synchronous and active-high. On reset:
  - state = HDR, hdr_cnt = 0;
  - m_hdr_valid = 0, m_pay_axis_tvalid/tlast/tuser = 0;
  - header fields = 0, both counters = 0.
- A beat is accepted when s_rx_axis_tvalid and s_rx_axis_trdy are both high.
- Reset mid-frame: the next accepted byte is treated as header byte 0; the upstream MAC is reset together with this block.
- HDR state:
  - Accepted bytes shift into a 112-bit capture register; hdr_cnt (4 bits) counts 0..13.
  - s_rx_axis_trdy = 1 while hdr_cnt < 13.
  - At hdr_cnt = 13, s_rx_axis_trdy = !m_hdr_valid || m_hdr_rdy, so the block stalls only while the previous header is still unaccepted.
  - Accepted byte with tlast = 1 at hdr_cnt <= 13 (runt, header only or shorter): frame dropped, stat_frames_drop += 1, hdr_cnt = 0, stay in HDR, no header emitted.
  - Accepted byte with tuser = 1 and tlast = 0: go to DROP.
  - Accepted byte with tuser = 1 and tlast = 1: handled as the runt case.
  - Byte 13 accepted with tlast = 0 and tuser = 0:
    - on the next edge, load the header outputs from the capture register plus byte 13, and set m_hdr_valid = 1;
    - stat_frames_ok += 1;
    - go to PAYLOAD.
- Header port: m_hdr_valid stays high and the fields stay stable until m_hdr_rdy is sampled high, then m_hdr_valid clears. If a new load and an acceptance fall on the same cycle, the load wins and m_hdr_valid stays 1.
- PAYLOAD state:
  - One-stage output register; latency is 1 cycle from input acceptance to m_pay_axis_tvalid.
  - s_rx_axis_trdy = !m_pay_axis_tvalid || m_pay_axis_trdy.
  - tdata, tlast and tuser are registered unmodified.
  - On acceptance of the input tlast beat: go to HDR, hdr_cnt = 0.
  - The payload stream is independent of m_hdr_rdy; payload may complete before the header is accepted.
- DROP state:
  - s_rx_axis_trdy = 1; all bytes are discarded.
  - On tlast: stat_frames_drop += 1, go to HDR, hdr_cnt = 0.
- Output register holding: m_pay_axis_tvalid clears when it is accepted and no new byte loads in the same cycle. Payload registers hold while tvalid = 1 and trdy = 0.
- Counters saturate at all-ones and never wrap.
- Back-to-back frames: byte 0 of frame N+1 may be accepted in the cycle after the tlast of frame N; no idle cycle is required.

Test Plan:
- 64-byte frame:
  - stimulus: dest 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, payload 0x00..0x31, all readies held 1;
  - required: m_hdr_valid for 1 cycle with exact fields;
  - required: 50 payload bytes 0x00..0x31 with tlast on 0x31;
  - required: stat_frames_ok = 1.
- 10-byte runt frame ending with tlast: no header and no payload beats; stat_frames_drop = 1; the next valid frame parses correctly.
- tuser = 1 on byte 5 of a 60-byte frame: no header and no payload output; s_rx_axis_trdy stays high through the frame's tlast; stat_frames_drop = 1.
- Two back-to-back 60-byte frames with m_hdr_rdy held 0 until cycle 200:
  - frame 2 stalls at its byte 13 (s_rx_axis_trdy = 0);
  - on release, the frame-1 header is accepted and the frame-2 header loads;
  - no bytes are lost or duplicated.
- Payload backpressure: m_pay_axis_trdy toggled with a random 50% duty cycle over a 1500-byte frame; the output byte sequence and the tlast position match the input exactly.
- Reset asserted mid-payload of frame 1:
  - all valids are 0 on the next edge;
  - the frame sent after reset parses with correct fields;
  - counters read 0 before that frame.

Source files
------------

// File: rtl/eth_rx_hdr_parser_if.sv
// Bundles the RX input stream, the header port and the payload output stream
// of the Ethernet RX header parser.
// slave  : the parser's view (consumes the RX stream, produces header/payload).
// master : the environment's view (MAC side plus header/payload consumers).
interface eth_rx_hdr_parser_if;
  // RX stream from the MAC
  logic [7:0]  s_rx_axis_tdata;
  logic        s_rx_axis_tvalid;
  logic        s_rx_axis_tlast;
  logic        s_rx_axis_tuser;
  logic        s_rx_axis_trdy;
  // Header port
  logic        m_hdr_valid;
  logic        m_hdr_rdy;
  logic [47:0] m_hdr_dest_mac;
  logic [47:0] m_hdr_src_mac;
  logic [15:0] m_hdr_eth_type;
  // Payload stream
  logic [7:0]  m_pay_axis_tdata;
  logic        m_pay_axis_tvalid;
  logic        m_pay_axis_tlast;
  logic        m_pay_axis_tuser;
  logic        m_pay_axis_trdy;

  modport slave (
    input  s_rx_axis_tdata, s_rx_axis_tvalid, s_rx_axis_tlast, s_rx_axis_tuser,
    output s_rx_axis_trdy,
    output m_hdr_valid, m_hdr_dest_mac, m_hdr_src_mac, m_hdr_eth_type,
    input  m_hdr_rdy,
    output m_pay_axis_tdata, m_pay_axis_tvalid, m_pay_axis_tlast, m_pay_axis_tuser,
    input  m_pay_axis_trdy
  );

  modport master (
    output s_rx_axis_tdata, s_rx_axis_tvalid, s_rx_axis_tlast, s_rx_axis_tuser,
    input  s_rx_axis_trdy,
    input  m_hdr_valid, m_hdr_dest_mac, m_hdr_src_mac, m_hdr_eth_type,
    output m_hdr_rdy,
    input  m_pay_axis_tdata, m_pay_axis_tvalid, m_pay_axis_tlast, m_pay_axis_tuser,
    output m_pay_axis_trdy
  );
endinterface

// File: rtl/eth_rx_hdr_parser.sv
// Ethernet RX header parser.
// Strips the 14-byte Ethernet header off each frame from the RX MAC, presents
// it on a valid/ready header port, and forwards the remaining bytes on an
// 8-bit stream through a one-stage output register. Runt frames and frames
// flagged bad inside the header are discarded and counted.
module eth_rx_hdr_parser #(
  parameter int DATA_WIDTH = 8,
  parameter int HDR_BYTES  = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  eth_rx_hdr_parser_if.slave   bus,
  output logic [CNT_WIDTH-1:0] stat_frames_ok,
  output logic [CNT_WIDTH-1:0] stat_frames_drop
);

  // Bytes 0..HDR_BYTES-2 are held in the capture register; the final header
  // byte is taken straight from the input bus when the header is loaded.
  localparam int         CAP_W    = (HDR_BYTES - 1) * DATA_WIDTH;
  localparam logic [3:0] HDR_LAST = 4'(HDR_BYTES - 1);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e               state_q,     state_d;
  logic [3:0]           hdr_cnt_q,   hdr_cnt_d;
  logic [CAP_W-1:0]     cap_q,       cap_d;
  logic                 hdr_valid_q, hdr_valid_d;
  logic [47:0]          dest_q,      dest_d;
  logic [47:0]          src_q,       src_d;
  logic [15:0]          type_q,      type_d;
  logic                 pay_valid_q, pay_valid_d;
  logic [7:0]           pay_data_q,  pay_data_d;
  logic                 pay_last_q,  pay_last_d;
  logic                 pay_user_q,  pay_user_d;
  logic [CNT_WIDTH-1:0] ok_q,        ok_d;
  logic [CNT_WIDTH-1:0] drop_q,      drop_d;

  logic rx_trdy_s;
  logic rx_accept_s;
  logic hdr_load_s;
  logic pay_load_s;

  // Input ready: in the header phase only the final header byte can stall,
  // waiting for the previous header to leave; payload follows the output
  // register; dropped frames are always drained at full rate.
  always_comb begin
    rx_trdy_s = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (hdr_cnt_q < HDR_LAST) begin
          rx_trdy_s = 1'b1;
        end else begin
          rx_trdy_s = !hdr_valid_q || bus.m_hdr_rdy;
        end
      end
      ST_PAYLOAD: rx_trdy_s = !pay_valid_q || bus.m_pay_axis_trdy;
      ST_DROP:    rx_trdy_s = 1'b1;
      default:    rx_trdy_s = 1'b0;
    endcase
  end

  assign rx_accept_s = bus.s_rx_axis_tvalid && rx_trdy_s;

  // Frame FSM next state, header capture, payload register and counters.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    cap_d       = cap_q;
    dest_d      = dest_q;
    src_d       = src_q;
    type_d      = type_q;
    pay_data_d  = pay_data_q;
    pay_last_d  = pay_last_q;
    pay_user_d  = pay_user_q;
    ok_d        = ok_q;
    drop_d      = drop_q;
    hdr_load_s  = 1'b0;
    pay_load_s  = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (rx_accept_s) begin
          cap_d = {cap_q[CAP_W-DATA_WIDTH-1:0], bus.s_rx_axis_tdata};
          if (bus.s_rx_axis_tlast) begin
            // Frame ended inside the header (error flag or not): runt.
            drop_d    = sat_inc(drop_q);
            hdr_cnt_d = 4'd0;
          end else if (bus.s_rx_axis_tuser) begin
            state_d   = ST_DROP;
            hdr_cnt_d = 4'd0;
          end else if (hdr_cnt_q == HDR_LAST) begin
            hdr_load_s = 1'b1;
            {dest_d, src_d, type_d} = {cap_q, bus.s_rx_axis_tdata};
            ok_d      = sat_inc(ok_q);
            state_d   = ST_PAYLOAD;
            hdr_cnt_d = 4'd0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end else begin
          hdr_cnt_d = hdr_cnt_q;
        end
      end
      ST_PAYLOAD: begin
        if (rx_accept_s) begin
          pay_load_s = 1'b1;
          pay_data_d = bus.s_rx_axis_tdata;
          pay_last_d = bus.s_rx_axis_tlast;
          pay_user_d = bus.s_rx_axis_tuser;
          if (bus.s_rx_axis_tlast) begin
            state_d   = ST_HDR;
            hdr_cnt_d = 4'd0;
          end else begin
            state_d   = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (rx_accept_s && bus.s_rx_axis_tlast) begin
          drop_d    = sat_inc(drop_q);
          state_d   = ST_HDR;
          hdr_cnt_d = 4'd0;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d   = ST_HDR;
        hdr_cnt_d = 4'd0;
      end
    endcase

    // A new header load takes priority over acceptance of the old one.
    if (hdr_load_s) begin
      hdr_valid_d = 1'b1;
    end else if (hdr_valid_q && bus.m_hdr_rdy) begin
      hdr_valid_d = 1'b0;
    end else begin
      hdr_valid_d = hdr_valid_q;
    end

    // Payload register: load beats over hold, hold while stalled.
    if (pay_load_s) begin
      pay_valid_d = 1'b1;
    end else if (pay_valid_q && bus.m_pay_axis_trdy) begin
      pay_valid_d = 1'b0;
    end else begin
      pay_valid_d = pay_valid_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      hdr_cnt_q   <= 4'd0;
      cap_q       <= {CAP_W{1'b0}};
      hdr_valid_q <= 1'b0;
      dest_q      <= 48'd0;
      src_q       <= 48'd0;
      type_q      <= 16'd0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= 8'd0;
      pay_last_q  <= 1'b0;
      pay_user_q  <= 1'b0;
      ok_q        <= {CNT_WIDTH{1'b0}};
      drop_q      <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      cap_q       <= cap_d;
      hdr_valid_q <= hdr_valid_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      type_q      <= type_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_last_q  <= pay_last_d;
      pay_user_q  <= pay_user_d;
      ok_q        <= ok_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.s_rx_axis_trdy    = rx_trdy_s;
  assign bus.m_hdr_valid       = hdr_valid_q;
  assign bus.m_hdr_dest_mac    = dest_q;
  assign bus.m_hdr_src_mac     = src_q;
  assign bus.m_hdr_eth_type    = type_q;
  assign bus.m_pay_axis_tdata  = pay_data_q;
  assign bus.m_pay_axis_tvalid = pay_valid_q;
  assign bus.m_pay_axis_tlast  = pay_last_q;
  assign bus.m_pay_axis_tuser  = pay_user_q;
  assign stat_frames_ok        = ok_q;
  assign stat_frames_drop      = drop_q;

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Scoreboard bench for eth_rx_hdr_parser: each frame's expected header and
// payload beats are derived from the frame bytes and pushed into queues; two
// monitors pop and compare whenever the DUT completes a handshake.
module tb_eth_rx_hdr_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] stat_ok;
  logic [15:0] stat_drop;

  always #5 clk = ~clk;

  eth_rx_hdr_parser_if bus ();

  eth_rx_hdr_parser #(.DATA_WIDTH(8), .HDR_BYTES(14), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .stat_frames_ok   (stat_ok),
    .stat_frames_drop (stat_drop)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [111:0] hdr_q [$];
  logic [9:0]   pay_q [$];
  int           exp_ok   = 0;
  int           exp_drop = 0;
  logic [7:0]   fr [0:2047];
  int           stall_arr [0:2047];

  bit pay_rand    = 1'b0;
  bit hdr_rand    = 1'b0;
  int hdr_release = 0;
  int hdr_valid_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Consumer readies, updated just after each rising edge.
  initial begin
    bus.m_hdr_rdy       = 1'b1;
    bus.m_pay_axis_trdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_pay_axis_trdy = pay_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_hdr_rdy       = hdr_rand ? 1'($urandom_range(0, 1)) : (cyc >= hdr_release);
    end
  end

  // Monitor: handshakes complete at the next rising edge, so sample on the falling edge.
  initial begin
    logic [111:0] hgot, hexp;
    logic [9:0]   pgot, pexp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.m_hdr_valid) hdr_valid_cycles++;
        if (bus.m_hdr_valid && bus.m_hdr_rdy) begin
          hgot = {bus.m_hdr_dest_mac, bus.m_hdr_src_mac, bus.m_hdr_eth_type};
          tests++;
          if (hdr_q.size() == 0) begin
            fails++;
            $display("FAIL hdr_unexpected: got %h expected no header", hgot);
          end else begin
            hexp = hdr_q.pop_front();
            if (hgot !== hexp) begin
              fails++;
              $display("FAIL hdr_fields: got %h expected %h", hgot, hexp);
            end
          end
        end
        if (bus.m_pay_axis_tvalid && bus.m_pay_axis_trdy) begin
          pgot = {bus.m_pay_axis_tdata, bus.m_pay_axis_tlast, bus.m_pay_axis_tuser};
          tests++;
          if (pay_q.size() == 0) begin
            fails++;
            $display("FAIL pay_unexpected: got %h expected no beat", pgot);
          end else begin
            pexp = pay_q.pop_front();
            if (pgot !== pexp) begin
              fails++;
              $display("FAIL pay_beat {data,last,user}: got %h expected %h", pgot, pexp);
            end
          end
        end
      end
    end
  end

  // Reference: a frame is dropped if it ends within 14 bytes or carries an
  // error flag inside its header; otherwise header and payload pass through.
  task automatic model_frame(input int len, input int err_idx);
    bit           drop;
    logic [111:0] h;
    drop = (len <= 14);
    for (int i = 0; i < 14 && i < len; i++) if (err_idx == i) drop = 1'b1;
    if (drop) begin
      exp_drop++;
    end else begin
      exp_ok++;
      h = '0;
      for (int i = 0; i < 14; i++) h = {h[103:0], fr[i]};
      hdr_q.push_back(h);
      for (int i = 14; i < len; i++)
        pay_q.push_back({fr[i], (i == len - 1) ? 1'b1 : 1'b0, (i == err_idx) ? 1'b1 : 1'b0});
    end
  endtask

  // Drive fr[0..abort_at-1] of a len-byte frame; stall cycles per byte land in stall_arr.
  task automatic send_frame(input int len, input int err_idx, input int abort_at);
    int w;
    model_frame(len, err_idx);
    for (int i = 0; i < abort_at; i++) begin
      bus.s_rx_axis_tvalid = 1'b1;
      bus.s_rx_axis_tdata  = fr[i];
      bus.s_rx_axis_tlast  = (i == len - 1);
      bus.s_rx_axis_tuser  = (i == err_idx);
      w = 0;
      forever begin
        @(negedge clk);
        if (bus.s_rx_axis_trdy) break;
        w++;
        if (w > 5000) begin
          fails++;
          $display("FAIL rx_stall_timeout: byte %0d never accepted", i);
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $fatal(1, "input stalled");
        end
      end
      stall_arr[i] = w;
      @(posedge clk);
      #1;
    end
    bus.s_rx_axis_tvalid = 1'b0;
    bus.s_rx_axis_tlast  = 1'b0;
    bus.s_rx_axis_tuser  = 1'b0;
  endtask

  task automatic fill_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    logic [111:0] h;
    h = {d, s, t};
    for (int i = 0; i < 14; i++) fr[i] = h[111 - 8*i -: 8];
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((hdr_q.size() != 0 || pay_q.size() != 0 || bus.m_hdr_valid || bus.m_pay_axis_tvalid)
           && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("queues_drained", 64'(hdr_q.size() + pay_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_ok"},   64'(stat_ok),   64'(exp_ok[15:0]));
    check({tag, "_stat_drop"}, 64'(stat_drop), 64'(exp_drop[15:0]));
  endtask

  initial begin
    int total;
    int len, err;
    reset                = 1'b1;
    bus.s_rx_axis_tvalid = 1'b0;
    bus.s_rx_axis_tdata  = 8'd0;
    bus.s_rx_axis_tlast  = 1'b0;
    bus.s_rx_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_hdr_valid", 64'(bus.m_hdr_valid), 64'd0);
    check("rst_pay_valid", 64'(bus.m_pay_axis_tvalid), 64'd0);
    check("rst_hdr_fields", 64'(bus.m_hdr_dest_mac ^ bus.m_hdr_src_mac) | 64'(bus.m_hdr_eth_type), 64'd0);
    check_stats("rst");

    // 64-byte frame with a known header and counting payload
    hdr_valid_cycles = 0;
    fill_hdr(48'h020000000001, 48'h020000000002, 16'h0800);
    for (int i = 14; i < 64; i++) fr[i] = 8'(i - 14);
    send_frame(64, -1, 64);
    drain();
    check("t1_hdr_valid_cycles", 64'(hdr_valid_cycles), 64'd1);
    check_stats("t1");

    // 10-byte runt, then a normal frame
    fill_random(10);
    send_frame(10, -1, 10);
    fill_random(60);
    send_frame(60, -1, 60);
    drain();
    check_stats("t2");

    // error flag on byte 5: frame discarded without stalling the input
    fill_random(60);
    send_frame(60, 5, 60);
    total = 0;
    for (int i = 0; i < 60; i++) total += stall_arr[i];
    check("t3_rx_stalls", 64'(total), 64'd0);
    drain();
    check_stats("t3");

    // two back-to-back frames, header port blocked for 200 cycles
    hdr_release = cyc + 200;
    fill_random(60);
    send_frame(60, -1, 60);
    fill_random(60);
    send_frame(60, -1, 60);
    check("t4_f2_byte13_stalled", 64'(stall_arr[13] > 10), 64'd1);
    drain();
    hdr_release = 0;
    check_stats("t4");

    // 1500-byte frame under random payload backpressure
    pay_rand = 1'b1;
    fill_random(1500);
    send_frame(1500, -1, 1500);
    drain();
    pay_rand = 1'b0;
    check_stats("t5");

    // reset in the middle of a frame's payload
    fill_random(60);
    send_frame(60, -1, 30);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_hdr_valid_after_rst", 64'(bus.m_hdr_valid), 64'd0);
    check("t6_pay_valid_after_rst", 64'(bus.m_pay_axis_tvalid), 64'd0);
    hdr_q.delete();
    pay_q.delete();
    exp_ok   = 0;
    exp_drop = 0;
    reset = 1'b0;
    check_stats("t6_pre");
    fill_random(60);
    send_frame(60, -1, 60);
    drain();
    check_stats("t6");

    // random frames, lengths, error positions and backpressure
    pay_rand = 1'b1;
    hdr_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, 80));
      err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      fill_random(len);
      send_frame(len, err, len);
    end
    drain();
    pay_rand = 1'b0;
    hdr_rand = 1'b0;
    check_stats("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
